// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Purpose  : Parametrised universal register with hold / load / shift /
//             rotate / clear modes and a self-timed parallel-to-serial burst
//             engine (start / busy / done handshake). Bits leave MSB-first
//             on ser_out, which is always the register MSB.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous reset, active low
//             mode     - operation select (sampled while idle)
//             d        - parallel data for load and burst start
//             sin_l    - fill bit for shift right (enters at MSB)
//             sin_r    - fill bit for shift left (enters at LSB)
//             start    - burst start request
//             q        - register contents
//             ser_out  - serial output (q[WIDTH-1])
//             busy     - high while a burst is in progress
//             done     - one-cycle pulse when a burst finishes
//  Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // WIDTH-1 always fits in clog2(WIDTH) bits, so the load value never truncates.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_CLR  = 3'b110;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_done;
    logic               w_done_nxt;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;   // done is a pulse: dropped unless a burst ends now

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // start outranks whatever mode is presented this cycle
                    w_q_nxt     = d;
                    w_cnt_nxt   = c_CNT_LAST;
                    w_state_nxt = S_SHIFT;
                end else begin
                    case (mode)
                        c_MODE_LOAD: w_q_nxt = d;
                        c_MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], sin_r};
                        c_MODE_SHR:  w_q_nxt = {sin_l, r_q[WIDTH-1:1]};
                        c_MODE_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                        c_MODE_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
                        c_MODE_CLR:  w_q_nxt = '0;
                        c_MODE_HOLD: w_q_nxt = r_q;
                        default:     w_q_nxt = r_q;   // 111 reserved: hold
                    endcase
                end
            end

            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end else begin
                    // Last bit (d[0]) has had its full cycle on ser_out;
                    // q is left as-is so ser_out keeps showing it.
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign q       = r_q;
    assign ser_out = r_q[WIDTH-1];
    assign busy    = (r_state == S_SHIFT);
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_univ_shift_reg
//  Purpose  : Self-checking bench for univ_shift_reg (WIDTH=4): table of
//             idle-mode vectors plus hand-written burst, back-to-back,
//             reset-during-burst and start-vs-clear sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int c_W = 4;

    logic           clk;
    logic           rst;
    logic [2:0]     mode;
    logic [c_W-1:0] d;
    logic           sin_l;
    logic           sin_r;
    logic           start;
    logic [c_W-1:0] q;
    logic           ser_out;
    logic           busy;
    logic           done;

    int n_pass;
    int n_total;

    univ_shift_reg #(.WIDTH(c_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .d       (d),
        .sin_l   (sin_l),
        .sin_r   (sin_r),
        .start   (start),
        .q       (q),
        .ser_out (ser_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]     mode;
        logic [c_W-1:0] d;
        logic           sin_l;
        logic           sin_r;
        logic [c_W-1:0] exp_q;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_status(input string name, input logic eq_busy, input logic eq_done);
        chk({name, " busy"}, 32'(busy), 32'(eq_busy));
        chk({name, " done"}, 32'(done), 32'(eq_done));
    endtask

    // Full burst: start edge, W data cycles, done cycle. On return the bench
    // is #1 after the completing edge (done cycle) with start=0, mode=hold.
    // Between start and completion mode/d are driven with load-of-zero noise.
    task automatic do_burst(input logic [c_W-1:0] dv);
        start = 1'b1;
        d     = dv;
        mode  = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 3'b001;
        d     = '0;
        for (int k = 0; k < c_W; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            chk($sformatf("burst %h bit%0d ser_out", dv, k), 32'(ser_out), 32'(dv[c_W-1-k]));
            chk_status($sformatf("burst %h bit%0d", dv, k), 1'b1, 1'b0);
        end
        @(posedge clk); #1;
        mode = 3'b000;
        chk_status($sformatf("burst %h end", dv), 1'b0, 1'b1);
        chk($sformatf("burst %h end ser_out", dv), 32'(ser_out), 32'(dv[0]));
        chk($sformatf("burst %h end q", dv), 32'(q), 32'({dv[0], 3'b000}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_W-1:0] eq;
        int             waited;

        n_pass  = 0;
        n_total = 0;

        //           mode    d        sin_l sin_r exp_q
        vecs[0]  = '{3'b001, 4'b1011, 1'b1, 1'b0, 4'b1011};  // load
        vecs[1]  = '{3'b010, 4'b0000, 1'b0, 1'b1, 4'b0111};  // shl, fill 1
        vecs[2]  = '{3'b011, 4'b1111, 1'b0, 1'b1, 4'b0011};  // shr, fill 0
        vecs[3]  = '{3'b011, 4'b0000, 1'b1, 1'b0, 4'b1001};  // shr, fill 1
        vecs[4]  = '{3'b100, 4'b1111, 1'b0, 1'b1, 4'b0011};  // rol 1001
        vecs[5]  = '{3'b001, 4'b1001, 1'b0, 1'b0, 4'b1001};  // load
        vecs[6]  = '{3'b101, 4'b0000, 1'b0, 1'b0, 4'b1100};  // ror 1001
        vecs[7]  = '{3'b010, 4'b1111, 1'b1, 1'b0, 4'b1000};  // shl, fill 0
        vecs[8]  = '{3'b100, 4'b0000, 1'b0, 1'b0, 4'b0001};  // rol wraps MSB
        vecs[9]  = '{3'b101, 4'b1111, 1'b1, 1'b1, 4'b1000};  // ror wraps LSB
        vecs[10] = '{3'b110, 4'b1111, 1'b1, 1'b1, 4'b0000};  // clear
        vecs[11] = '{3'b001, 4'b0110, 1'b0, 1'b0, 4'b0110};  // load
        vecs[12] = '{3'b000, 4'b1111, 1'b1, 1'b1, 4'b0110};  // hold x3
        vecs[13] = '{3'b000, 4'b0000, 1'b1, 1'b1, 4'b0110};
        vecs[14] = '{3'b000, 4'b1001, 1'b0, 1'b0, 4'b0110};
        vecs[15] = '{3'b111, 4'b1111, 1'b1, 1'b1, 4'b0110};  // reserved = hold
        vecs[16] = '{3'b111, 4'b0001, 1'b0, 1'b0, 4'b0110};

        // ---------------- reset ----------------
        rst   = 1'b0;
        mode  = 3'b000;
        d     = '0;
        sin_l = 1'b0;
        sin_r = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q", 32'(q), 32'h0);
        chk_status("reset", 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("after release q", 32'(q), 32'h0);
        chk_status("after release", 1'b0, 1'b0);

        // ---------------- idle mode table ----------------
        foreach (vecs[i]) begin
            mode  = vecs[i].mode;
            d     = vecs[i].d;
            sin_l = vecs[i].sin_l;
            sin_r = vecs[i].sin_r;
            @(posedge clk); #1;
            eq = vecs[i].exp_q;
            chk($sformatf("vec%0d q", i), 32'(q), 32'(eq));
            chk($sformatf("vec%0d ser_out", i), 32'(ser_out), 32'(eq[c_W-1]));
            chk_status($sformatf("vec%0d", i), 1'b0, 1'b0);
        end
        mode = 3'b000;

        // ---------------- single burst, then back-to-back ----------------
        do_burst(4'b1101);
        do_burst(4'b0110);
        @(posedge clk); #1;
        chk_status("post burst idle", 1'b0, 1'b0);
        chk("post burst q hold", 32'(q), 32'h0);

        // ---------------- reset during a burst ----------------
        start = 1'b1;
        d     = 4'b1011;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid burst ser_out bit1", 32'(ser_out), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset q", 32'(q), 32'h0);
        chk_status("async reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < c_W + 2; c++) begin
            @(posedge clk); #1;
            chk_status($sformatf("post reset idle c%0d", c), 1'b0, 1'b0);
            chk($sformatf("post reset q c%0d", c), 32'(q), 32'h0);
        end

        // ---------------- start beats clear ----------------
        start = 1'b1;
        mode  = 3'b110;
        d     = 4'b1010;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 3'b000;
        chk("start vs clear q", 32'(q), 32'hA);
        chk_status("start vs clear", 1'b1, 1'b0);
        waited = 0;
        while (done !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("start vs clear done cycles", 32'(waited), 32'(c_W));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal register, successor to the fixed 4-bit parallel-in/parallel-out register. It adds programmable width, synchronous hold/load/shift/rotate/clear modes and a self-timed parallel-to-serial burst engine with a start/busy/done handshake. It sits between parallel datapath logic and single-wire serial links. It also serves as a general storage and shift stage.

## Interface
- WIDTH, 4, register width in bits; legal range 2..32
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- mode  in  3  operation select, sampled at each rising edge while idle
- d  in  WIDTH  parallel data, used by load and serializer start
- sin_l  in  1  serial fill bit for shift right, enters at the MSB
- sin_r  in  1  serial fill bit for shift left, enters at the LSB
- start  in  1  serializer start request, single-cycle or level
- q  out  WIDTH  register contents
- ser_out  out  1  serial output; always equals q[WIDTH-1]
- busy  out  1  high while a serial burst is in progress
- done  out  1  one-cycle pulse when a burst finishes

## Operation
- Reset (rst=0, asynchronous, takes effect immediately): q=0, busy=0, done=0, internal bit counter cnt=0.
- Idle (busy=0): each rising edge applies mode to q.
  - 000: hold.
  - 001: load, q<=d.
  - 010: shift left, q<={q[W-2:0],sin_r}.
  - 011: shift right, q<={sin_l,q[W-1:1]}.
  - 100: rotate left, q<={q[W-2:0],q[W-1]}.
  - 101: rotate right, q<={q[0],q[W-1:1]}.
  - 110: clear, q<=0.
  - 111: reserved; behaves as hold.
- Serializer, state IDLE:
  - start=1 at an edge gives q<=d, busy<=1 and cnt<=WIDTH-1, then moves to SHIFT.
  - start has priority over mode in that cycle.
- Serializer, state SHIFT (busy=1):
  - mode, d, sin_l and sin_r are ignored; start is ignored.
  - If cnt!=0 at an edge: q<={q[W-2:0],1'b0} and cnt<=cnt-1.
  - If cnt==0 at an edge: q is unchanged, busy<=0 and done<=1; state returns to IDLE.
- Bits leave MSB-first: d[W-1], d[W-2], ... d[0].
- done is high for exactly one cycle. It is cleared at the next edge unless a new burst completes at that edge.
- cnt width is clog2(WIDTH). The counter never wraps below 0.

## Timing
- Edge E0 samples start=1. After E0: ser_out=d[W-1] and busy=1.
- After edge Ek, for k=0..W-1: ser_out=d[W-1-k]. Each bit is valid for exactly one clock.
- After edge EW: busy=0, done=1, and ser_out still shows d[0].
- busy stays high for exactly WIDTH cycles. done rises WIDTH cycles after the start edge.
- Back-to-back bursts: start=1 in the done=1 cycle is accepted at that edge. This gives 1 idle-status cycle between bursts, and no bit is lost.
- Mode operations have a latency of 1 edge. q updates only on rising edges, except on reset.
- Reset during a burst: outputs go to their reset values immediately. After release the block is in IDLE and no done pulse is produced.
- start and a non-hold mode in the same idle cycle: start wins and the mode is discarded.

## Test plan
- WIDTH=4, reset, then release -> q=0000, busy=0, done=0. Then mode=001 with d=1011 -> q=1011 after 1 edge.
- q=1011:
  - mode=010, sin_r=1 -> 0111.
  - mode=011, sin_l=0 -> 0011.
  - mode=100 on 1001 -> 0011.
  - mode=101 on 1001 -> 1100.
  - mode=110 -> 0000.
  - mode=000 holds for 3 cycles.
- start=1 with d=1101 -> ser_out sequence 1,1,0,1 over 4 cycles, busy high for 4 cycles, then done high for 1 cycle. mode=001 with d=0000 toggled during the burst has no effect.
- Back-to-back: second start with d=0110 in the done cycle -> sequence 1,1,0,1 then 0,1,1,0, with busy low for exactly 1 cycle between the bursts.
- Assert rst after the 2nd bit of a burst -> q=0 and busy=0 immediately. No done pulse, and the block idles with mode=000.
- start=1 and mode=110 in the same idle cycle -> q=d and busy=1, not cleared.
